// File: rtl/controller_interface_if.sv
// Controller-port and CPU-read-bus signals for the dual NES controller poller.
// The master side is the poller; the slave side is the pads and CPU decode.
interface controller_interface_if;
    logic       controller_clk;
    logic       controller_latch;
    logic       controller_1_data_in_B;
    logic       controller_2_data_in_B;
    logic       SELECT_controller_1;
    logic       SELECT_controller_2;
    logic [7:0] data_out;
    logic       data_enable;

    modport master (
        output controller_clk,
        output controller_latch,
        input  controller_1_data_in_B,
        input  controller_2_data_in_B,
        input  SELECT_controller_1,
        input  SELECT_controller_2,
        output data_out,
        output data_enable
    );

    modport slave (
        input  controller_clk,
        input  controller_latch,
        output controller_1_data_in_B,
        output controller_2_data_in_B,
        output SELECT_controller_1,
        output SELECT_controller_2,
        input  data_out,
        input  data_enable
    );
endinterface

// File: rtl/controller_interface.sv
// Polls two NES-style serial controllers in parallel (latch, 8 reads, 8 clock pulses)
// and presents the active-high button bytes on the CPU read bus.
module controller_interface #(
    parameter int CLK_DIV = 6
) (
    input  logic                   clk_12_5875,
    input  logic                   rst_B,
    input  logic                   poll_start,
    controller_interface_if.master bus,
    output logic [7:0]             controller_1_buttons_out,
    output logic [7:0]             controller_2_buttons_out
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        READ,
        PULSE
    } state_t;

    state_t        state, state_next;
    logic [2:0]    bit_idx, bit_next;
    logic [TW-1:0] tick_cnt, tick_next;
    logic          tick_last;
    logic          sample_bit;
    logic          load_buttons;

    logic [1:0]    poll_sync;
    logic          poll_prev;
    logic [1:0]    d1_sync;
    logic [1:0]    d2_sync;
    logic          start_edge;

    logic [7:0]    shift_1, shift_2;
    logic          latch_q, clk_q;

    assign start_edge = poll_sync[1] & ~poll_prev;
    assign tick_last  = (tick_cnt == TICK_LAST);

    // NOTE: every variable is given a default before the case so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next   = state;
        bit_next     = bit_idx;
        tick_next    = tick_last ? '0 : tick_cnt + 1'b1;
        sample_bit   = 1'b0;
        load_buttons = 1'b0;
        unique case (state)
            IDLE: begin
                tick_next = '0;
                bit_next  = 3'd0;
                if (start_edge) state_next = LATCH;
            end
            LATCH: begin
                if (tick_last) state_next = READ;
            end
            READ: begin
                if (tick_last) begin
                    sample_bit = 1'b1;
                    state_next = PULSE;
                end
            end
            PULSE: begin
                if (tick_last) begin
                    if (bit_idx == 3'd7) begin
                        load_buttons = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        state_next = READ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            state                    <= IDLE;
            bit_idx                  <= 3'd0;
            tick_cnt                 <= '0;
            poll_sync                <= 2'b00;
            poll_prev                <= 1'b0;
            d1_sync                  <= 2'b00;
            d2_sync                  <= 2'b00;
            shift_1                  <= 8'h00;
            shift_2                  <= 8'h00;
            controller_1_buttons_out <= 8'h00;
            controller_2_buttons_out <= 8'h00;
            latch_q                  <= 1'b0;
            clk_q                    <= 1'b0;
        end else begin
            poll_sync <= {poll_sync[0], poll_start};
            poll_prev <= poll_sync[1];
            d1_sync   <= {d1_sync[0], bus.controller_1_data_in_B};
            d2_sync   <= {d2_sync[0], bus.controller_2_data_in_B};

            state    <= state_next;
            bit_idx  <= bit_next;
            tick_cnt <= tick_next;

            // Pad lines are registered from the next state so they change
            // on the same edge as the FSM and never glitch.
            latch_q <= (state_next == LATCH);
            clk_q   <= (state_next == PULSE);

            // Data lines are active-low; first bit received lands in bit 7.
            if (sample_bit) begin
                shift_1[3'd7 - bit_idx] <= ~d1_sync[1];
                shift_2[3'd7 - bit_idx] <= ~d2_sync[1];
            end

            if (load_buttons) begin
                controller_1_buttons_out <= shift_1;
                controller_2_buttons_out <= shift_2;
            end
        end
    end

    assign bus.controller_latch = latch_q;
    assign bus.controller_clk   = clk_q;

    // Controller 1 wins when both registers are selected.
    always_comb begin
        bus.data_enable = bus.SELECT_controller_1 | bus.SELECT_controller_2;
        if (bus.SELECT_controller_1)      bus.data_out = controller_1_buttons_out;
        else if (bus.SELECT_controller_2) bus.data_out = controller_2_buttons_out;
        else                              bus.data_out = 8'h00;
    end

endmodule

// File: tb/tb_controller_interface.sv
// Self-checking bench for controller_interface: behavioural NES pads plus a
// scoreboard of expected button bytes popped when each poll completes.
module tb_controller_interface;

    localparam int D    = 6;
    localparam int POLL = 17 * D;

    logic clk_12_5875 = 1'b0;
    logic rst_B       = 1'b0;
    logic poll_start  = 1'b0;
    logic [7:0] b1, b2;

    controller_interface_if bus ();

    controller_interface #(.CLK_DIV(D)) dut (
        .clk_12_5875              (clk_12_5875),
        .rst_B                    (rst_B),
        .poll_start               (poll_start),
        .bus                      (bus),
        .controller_1_buttons_out (b1),
        .controller_2_buttons_out (b2)
    );

    always #5 clk_12_5875 = ~clk_12_5875;

    // Pad model: latch loads the pressed byte, each controller_clk rise
    // shifts the next button out; data line is low while a button is pressed.
    logic [7:0] pressed1 = 8'h00, pressed2 = 8'h00;
    logic [7:0] sr1 = 8'h00, sr2 = 8'h00;
    always @(posedge bus.controller_clk or posedge bus.controller_latch) begin
        if (bus.controller_latch) begin
            sr1 <= pressed1;
            sr2 <= pressed2;
        end else begin
            sr1 <= {sr1[6:0], 1'b0};
            sr2 <= {sr2[6:0], 1'b0};
        end
    end
    assign bus.controller_1_data_in_B = ~sr1[7];
    assign bus.controller_2_data_in_B = ~sr2[7];

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  cur1 = 8'h00, cur2 = 8'h00;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // mode 0: plain poll; 1: extra start edge mid-poll; 2: reset during READ[3]
    task automatic do_poll(input logic [7:0] p1, input logic [7:0] p2, input int mode);
        int waited, rises, bad_width, hi_cnt, hold_bad, extra;
        logic prev_clk;
        logic [15:0] exp;
        waited = 0; rises = 0; bad_width = 0; hi_cnt = 0; hold_bad = 0; extra = 0;
        prev_clk = 1'b0;
        pressed1 = p1;
        pressed2 = p2;
        if (mode != 2) exp_q.push_back({p1, p2});

        @(negedge clk_12_5875);
        poll_start = 1'b1;
        while (!bus.controller_latch && waited < 20) begin
            @(negedge clk_12_5875);
            waited++;
            if (waited == 3) poll_start = 1'b0;
        end
        poll_start = 1'b0;
        if (!bus.controller_latch) begin
            check("latch_timeout", 16'd0, 16'd1);
            if (mode != 2) void'(exp_q.pop_back());
            return;
        end

        for (int n = 1; n <= POLL; n++) begin
            @(negedge clk_12_5875);
            if (mode == 1 && n == 5 * D)     poll_start = 1'b1;
            if (mode == 1 && n == 5 * D + 4) poll_start = 1'b0;
            if (mode == 2 && n == 7 * D + 2) begin
                rst_B = 1'b0;
                #1;
                check("rst_buttons", {b1, b2}, 16'h0000);
                check("rst_latch", {15'd0, bus.controller_latch}, 16'd0);
                check("rst_cclk", {15'd0, bus.controller_clk}, 16'd0);
                repeat (3) @(negedge clk_12_5875);
                rst_B = 1'b1;
                cur1 = 8'h00;
                cur2 = 8'h00;
                return;
            end
            if (bus.controller_clk) begin
                if (!prev_clk) rises++;
                hi_cnt++;
            end else if (prev_clk) begin
                if (hi_cnt != D) bad_width++;
                hi_cnt = 0;
            end
            prev_clk = bus.controller_clk;
            if (n < POLL && {b1, b2} !== {cur1, cur2}) hold_bad++;
        end

        check("hold_old", 16'(hold_bad), 16'd0);
        check("clk_pulses", 16'(rises), 16'd8);
        check("clk_width", 16'(bad_width), 16'd0);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 16'd0, 16'd1);
        end else begin
            exp = exp_q.pop_front();
            check("buttons", {b1, b2}, exp);
        end
        cur1 = p1;
        cur2 = p2;

        if (mode == 1) begin
            prev_clk = bus.controller_latch;
            for (int n = 0; n < POLL + 20; n++) begin
                @(negedge clk_12_5875);
                if (bus.controller_latch && !prev_clk) extra++;
                prev_clk = bus.controller_latch;
            end
            check("no_requeue", 16'(extra), 16'd0);
        end
    endtask

    task automatic cpu_read(input string tag, input logic s1, input logic s2,
                            input logic [7:0] exp_data, input logic exp_en);
        bus.SELECT_controller_1 = s1;
        bus.SELECT_controller_2 = s2;
        #1;
        check({tag, "_data"}, {8'h00, bus.data_out}, {8'h00, exp_data});
        check({tag, "_en"}, {15'd0, bus.data_enable}, {15'd0, exp_en});
    endtask

    initial begin
        bus.SELECT_controller_1 = 1'b0;
        bus.SELECT_controller_2 = 1'b0;
        repeat (4) @(negedge clk_12_5875);
        check("reset_buttons", {b1, b2}, 16'h0000);
        check("reset_latch", {15'd0, bus.controller_latch}, 16'd0);
        check("reset_cclk", {15'd0, bus.controller_clk}, 16'd0);
        check("reset_den", {15'd0, bus.data_enable}, 16'd0);
        rst_B = 1'b1;
        repeat (3) @(negedge clk_12_5875);

        do_poll(8'b10001001, 8'b00100110, 0);

        cpu_read("sel1", 1'b1, 1'b0, 8'h89, 1'b1);
        cpu_read("sel2", 1'b0, 1'b1, 8'h26, 1'b1);
        cpu_read("both", 1'b1, 1'b1, 8'h89, 1'b1);
        cpu_read("none", 1'b0, 1'b0, 8'h00, 1'b0);

        do_poll(8'h5A, 8'hC3, 1);
        do_poll(8'hFF, 8'h00, 2);
        repeat (3) @(negedge clk_12_5875);
        do_poll(8'h81, 8'h00, 0);
        cpu_read("post_sel2", 1'b0, 1'b1, 8'h00, 1'b1);
        cpu_read("post_sel1", 1'b1, 1'b0, 8'h81, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
